iter_divmod: RTL and testbench

ITER_DIVMOD -- requirements
Module: iter_divmod

---
 rtl/iter_divmod_pkg.sv | 17 +
 rtl/iter_divmod_step.sv | 27 ++
 rtl/iter_divmod.sv | 110 +++++++++++
 tb/tb_iter_divmod.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/iter_divmod_pkg.sv
// Shared definitions for the iterative divider: FSM state type and opcode values.
`default_nettype none

package iter_divmod_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] kDIV = 4'd0;
  localparam logic [3:0] kMOD = 4'd1;

endpackage

`default_nettype wire

// File: rtl/iter_divmod_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
`default_nettype none

module divmod_step #(
  parameter int W = 8
) (
  input  logic [W:0]   i_rem,
  input  logic         i_bit,
  input  logic [W-1:0] i_divisor,
  output logic [W:0]   o_rem,
  output logic         o_quo_bit
);

  logic [W:0] w_shifted;
  logic [W:0] w_diff;

  assign w_shifted = {i_rem[W-1:0], i_bit};
  assign w_diff    = w_shifted - {1'b0, i_divisor};

  // A set top bit means the true shifted value exceeds W+1 bits, so the divisor always fits;
  // the modular subtraction still yields the exact remainder in that case.
  assign o_quo_bit = i_rem[W] | (w_shifted >= {1'b0, i_divisor});
  assign o_rem     = o_quo_bit ? w_diff : w_shifted;

endmodule

`default_nettype wire

// File: rtl/iter_divmod.sv
// Iterative unsigned divider/modulo: one restoring step per clock, W steps per operation.
`default_nettype none

module iter_divmod
  import iter_divmod_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         div_by_zero
);

  localparam int CW = $clog2(W + 1);

  state_t         r_state;
  state_t         w_state_next;
  logic [3:0]     r_op;
  logic [W-1:0]   r_divisor;
  logic [W-1:0]   r_quo;
  logic [W:0]     r_rem;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_result;
  logic           r_dz;

  logic           w_accept;
  logic           w_last;
  logic [W:0]     w_rem_next;
  logic           w_qbit;
  logic [W-1:0]   w_quo_next;

  assign w_accept = start && (r_state != RUN);
  assign w_last   = (r_state == RUN) && (r_cnt == CW'(1));

  // r_quo starts as the dividend; its MSB feeds each step while quotient bits shift in at the LSB.
  divmod_step #(.W(W)) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_quo[W-1]),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_next),
    .o_quo_bit (w_qbit)
  );

  assign w_quo_next = {r_quo[W-2:0], w_qbit};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      RUN: begin
        if (w_last) w_state_next = DONE;
      end
      default: begin
        if (start) w_state_next = (divisor == '0) ? DONE : RUN;
        else       w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op      <= '0;
      r_divisor <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_dz      <= 1'b0;
    end else if (w_accept) begin
      r_op      <= op;
      r_divisor <= divisor;
      r_quo     <= dividend;
      r_rem     <= '0;
      if (divisor == '0) begin
        r_cnt    <= '0;
        r_result <= (op == kMOD) ? dividend : '1;
        r_dz     <= 1'b1;
      end else begin
        r_cnt    <= CW'(W);
      end
    end else if (r_state == RUN) begin
      r_rem <= w_rem_next;
      r_quo <= w_quo_next;
      r_cnt <= r_cnt - CW'(1);
      if (w_last) begin
        r_result <= (r_op == kMOD) ? w_rem_next[W-1:0] : w_quo_next;
        r_dz     <= 1'b0;
      end
    end
  end

  assign busy        = (r_state == RUN);
  assign done        = (r_state == DONE);
  assign result      = r_result;
  assign div_by_zero = r_dz;

endmodule

`default_nettype wire

// File: tb/tb_iter_divmod.sv
// Directed, table-driven bench for iter_divmod (W=8) plus hand-written multi-cycle sequences.
`default_nettype none

module tb_iter_divmod;
  import iter_divmod_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         div_by_zero;

  int checks;
  int failures;

  iter_divmod #(.W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp_edges: rising edges after the accepting edge until done is seen (W normally, 0 for divisor 0).
  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_r;
    logic       exp_dz;
    int         exp_edges;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Drives one start on a falling edge, then counts edges and busy samples until done (bounded).
  task automatic run_op(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                        output int edges, output int bcnt);
    @(negedge clk);
    start = 1'b1; op = o; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0;
    bcnt  = 0;
    while (!done && edges < 20) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  initial begin
    int edges;
    int bcnt;
    int seen;

    checks = 0; failures = 0;
    vecs[0]  = '{kDIV,  8'd100, 8'd7,   8'd14,  1'b0, 8};
    vecs[1]  = '{kMOD,  8'd100, 8'd7,   8'd2,   1'b0, 8};
    vecs[2]  = '{kDIV,  8'd255, 8'd1,   8'd255, 1'b0, 8};
    vecs[3]  = '{kMOD,  8'd5,   8'd9,   8'd5,   1'b0, 8};
    vecs[4]  = '{kDIV,  8'd5,   8'd9,   8'd0,   1'b0, 8};
    vecs[5]  = '{kDIV,  8'd42,  8'd0,   8'd255, 1'b1, 0};
    vecs[6]  = '{kMOD,  8'd42,  8'd0,   8'd42,  1'b1, 0};
    vecs[7]  = '{kDIV,  8'd255, 8'd255, 8'd1,   1'b0, 8};
    vecs[8]  = '{kMOD,  8'd255, 8'd16,  8'd15,  1'b0, 8};
    vecs[9]  = '{kDIV,  8'd0,   8'd5,   8'd0,   1'b0, 8};
    vecs[10] = '{kMOD,  8'd254, 8'd255, 8'd254, 1'b0, 8};
    vecs[11] = '{kDIV,  8'd128, 8'd2,   8'd64,  1'b0, 8};
    vecs[12] = '{4'hF,  8'd100, 8'd7,   8'd14,  1'b0, 8};
    vecs[13] = '{kMOD,  8'd200, 8'd13,  8'd5,   1'b0, 8};

    reset = 1'b1; start = 1'b0; op = kDIV; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    check("reset_dz", div_by_zero, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, edges, bcnt);
      check($sformatf("v%0d_latency", i), edges, vecs[i].exp_edges);
      check($sformatf("v%0d_result", i), result, vecs[i].exp_r);
      check($sformatf("v%0d_dz", i), div_by_zero, vecs[i].exp_dz);
      check($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].exp_edges);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", i), done, 0);
      check($sformatf("v%0d_result_hold", i), result, vecs[i].exp_r);
    end

    // 200/3 with starts and operand changes while running; then back-to-back 9%2 from DONE.
    @(negedge clk);
    start = 1'b1; op = kDIV; dividend = 8'd200; divisor = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (k >= 1 && k <= 4) begin
        start = 1'b1; op = kMOD; dividend = 8'(k * 37); divisor = 8'(k);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
    end
    check("ignore_latency", edges, 8);
    check("ignore_result", result, 66);
    check("ignore_dz", div_by_zero, 0);
    start = 1'b1; op = kMOD; dividend = 8'd9; divisor = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_done_low", done, 0);
    check("b2b_result_held", result, 66);
    edges = 0;
    while (!done && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check("b2b_latency", edges, 8);
    check("b2b_result", result, 1);

    // Reset four cycles into a run: outputs clear immediately, no done follows.
    @(negedge clk);
    start = 1'b1; op = kDIV; dividend = 8'd100; divisor = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_dz", div_by_zero, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    check("abort_no_done", seen, 0);
    run_op(kDIV, 8'd50, 8'd5, edges, bcnt);
    check("after_abort_latency", edges, 8);
    check("after_abort_result", result, 10);
    check("after_abort_busy_cycles", bcnt, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
